rob_recovery_ctrl: RTL and testbench

//  Sequences precise-state recovery at ROB retirement. It watches the 3 retire slots and

---
 rtl/rob_recovery_ctrl_pkg.sv | 20 ++
 rtl/rob_recovery_ctrl_oldest_hit_sel.sv | 30 +++
 rtl/rob_recovery_ctrl.sv | 121 ++++++++++++
 tb/tb_rob_recovery_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rob_recovery_ctrl_pkg.sv
// Shared definitions for the ROB precise-state recovery controller.
// Slot numbering: slot 2 is the oldest retire slot, slot 0 the youngest.
package rob_recovery_ctrl_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned NUM_SLOTS   = 3;
    localparam int unsigned OLDEST_SLOT = 2;

    typedef enum logic [1:0] {
        RCV_IDLE,
        RCV_FLUSH,
        RCV_DRAIN
    } recover_state_t;

    // Redirect targets are word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rob_recovery_ctrl_oldest_hit_sel.sv
// Priority picker over the retire slots: one-hot select of the oldest hit and a mask of
// that slot plus every older slot (all ones when nothing hits).
module rob_recovery_ctrl_oldest_hit_sel
    import rob_recovery_ctrl_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] i_hit,
    output logic [NUM_SLOTS-1:0] o_sel,
    output logic [NUM_SLOTS-1:0] o_keep_mask,
    output logic                 o_any_hit
);

    logic w_found;

    always_comb begin
        o_sel       = '0;
        o_keep_mask = '1;
        o_any_hit   = |i_hit;
        w_found     = 1'b0;
        // Walk oldest to youngest; once a hit is taken, every younger slot is dropped.
        for (int k = int'(OLDEST_SLOT); k >= 0; k--) begin
            if (w_found) begin
                o_keep_mask[k] = 1'b0;
            end else if (i_hit[k]) begin
                o_sel[k] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_recovery_ctrl.sv
// Sequences precise-state recovery at retirement: gates retire commits, issues the one-cycle
// flush/redirect pulse and holds dispatch until the store queue drains.
module rob_recovery_ctrl
    import rob_recovery_ctrl_pkg::*;
#(
    parameter int unsigned MIN_HOLD = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_SLOTS-1:0]      i_retire_valid,
    input  logic [NUM_SLOTS-1:0]      i_retire_precise,
    input  logic [NUM_SLOTS*XLEN-1:0] i_retire_target_pc,
    input  logic                      i_sq_drained,
    output logic [NUM_SLOTS-1:0]      o_retire_commit,
    output logic                      o_bp_recover_en,
    output logic                      o_fetch_redirect_valid,
    output logic [XLEN-1:0]           o_fetch_redirect_pc,
    output logic                      o_dispatch_hold,
    output logic [CNT_W-1:0]          o_recover_count
);

    localparam int unsigned        HOLD_W    = $clog2(MIN_HOLD + 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(MIN_HOLD);
    localparam logic [HOLD_W-1:0]  HOLD_EXIT = HOLD_W'(MIN_HOLD - 1);

    recover_state_t        r_state, w_state_next;
    logic [HOLD_W-1:0]     r_hold_cnt, w_hold_cnt_next;
    logic                  r_flush, w_flush_next;
    logic                  r_hold, w_hold_next;
    logic [XLEN-1:0]       r_redirect_pc, w_redirect_pc_next;
    logic [CNT_W-1:0]      r_count, w_count_next;

    logic [NUM_SLOTS-1:0]  w_hit, w_sel, w_keep_mask, w_commit;
    logic                  w_any_hit;
    logic [XLEN-1:0]       w_sel_pc;

    assign w_hit = i_retire_valid & i_retire_precise;

    rob_recovery_ctrl_oldest_hit_sel u_oldest_hit_sel (
        .i_hit       (w_hit),
        .o_sel       (w_sel),
        .o_keep_mask (w_keep_mask),
        .o_any_hit   (w_any_hit)
    );

    always_comb begin
        w_sel_pc = '0;
        for (int k = 0; k < int'(NUM_SLOTS); k++) begin
            if (w_sel[k]) begin
                w_sel_pc = w_sel_pc | i_retire_target_pc[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_hold_cnt_next    = r_hold_cnt;
        w_flush_next       = 1'b0;
        w_hold_next        = r_hold;
        w_redirect_pc_next = r_redirect_pc;
        w_count_next       = r_count;
        w_commit           = '0;
        unique case (r_state)
            RCV_IDLE: begin
                w_commit = i_retire_valid & w_keep_mask;
                if (w_any_hit) begin
                    w_state_next       = RCV_FLUSH;
                    w_flush_next       = 1'b1;
                    w_hold_next        = 1'b1;
                    w_redirect_pc_next = align_pc(w_sel_pc);
                    if (r_count != '1) begin
                        w_count_next = r_count + 1'b1;
                    end
                end
            end
            RCV_FLUSH: begin
                w_state_next    = RCV_DRAIN;
                w_hold_cnt_next = '0;
            end
            RCV_DRAIN: begin
                if ((r_hold_cnt >= HOLD_EXIT) && i_sq_drained) begin
                    w_state_next = RCV_IDLE;
                    w_hold_next  = 1'b0;
                end else if (r_hold_cnt != HOLD_MAX) begin
                    w_hold_cnt_next = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = RCV_IDLE;
                w_hold_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= RCV_IDLE;
            r_hold_cnt    <= '0;
            r_flush       <= 1'b0;
            r_hold        <= 1'b0;
            r_redirect_pc <= '0;
            r_count       <= '0;
        end else begin
            r_state       <= w_state_next;
            r_hold_cnt    <= w_hold_cnt_next;
            r_flush       <= w_flush_next;
            r_hold        <= w_hold_next;
            r_redirect_pc <= w_redirect_pc_next;
            r_count       <= w_count_next;
        end
    end

    assign o_retire_commit        = w_commit;
    assign o_bp_recover_en        = r_flush;
    assign o_fetch_redirect_valid = r_flush;
    assign o_fetch_redirect_pc    = r_redirect_pc;
    assign o_dispatch_hold        = r_hold;
    assign o_recover_count        = r_count;

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Scoreboard bench for rob_recovery_ctrl: the driver queues expected commits and redirects,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_rob_recovery_ctrl;
    import rob_recovery_ctrl_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  cnt;
    } redir_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  valid;
    logic [2:0]  precise;
    logic [95:0] target;
    logic        drained;
    logic [2:0]  commit;
    logic        bp;
    logic        rv;
    logic [31:0] pc;
    logic        hold;
    logic [3:0]  cnt;

    int          n_pass;
    int          n_total;
    logic [3:0]  exp_cnt;
    logic        prev_bp;
    logic [2:0]  mon_commit;
    redir_t      mon_redir;

    logic [2:0]  q_commit[$];
    redir_t      q_redir[$];

    rob_recovery_ctrl #(
        .MIN_HOLD (2),
        .CNT_W    (4)
    ) u_dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_retire_valid         (valid),
        .i_retire_precise       (precise),
        .i_retire_target_pc     (target),
        .i_sq_drained           (drained),
        .o_retire_commit        (commit),
        .o_bp_recover_en        (bp),
        .o_fetch_redirect_valid (rv),
        .o_fetch_redirect_pc    (pc),
        .o_dispatch_hold        (hold),
        .o_recover_count        (cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (q_commit.size() > 0) begin
                mon_commit = q_commit.pop_front();
                chk("retire_commit", 32'(commit), 32'(mon_commit));
            end
            if (bp || rv) begin
                if (q_redir.size() == 0) begin
                    chk("spurious_flush", 32'({bp, rv}), 32'd0);
                end else begin
                    mon_redir = q_redir.pop_front();
                    chk("redirect_pc", pc, mon_redir.pc);
                    chk("recover_count_at_flush", 32'(cnt), 32'(mon_redir.cnt));
                    chk("flush_pulse_pair", 32'({bp, rv}), 32'd3);
                    chk("flush_one_cycle", 32'(prev_bp), 32'd0);
                    chk("hold_at_flush", 32'(hold), 32'd1);
                end
            end
        end
        prev_bp <= bp;
    end

    task automatic step(input logic [2:0] v, input logic [2:0] p, input logic [31:0] t2,
                        input logic [31:0] t1, input logic [31:0] t0, input logic drn,
                        input logic [2:0] exp_commit);
        valid   = v;
        precise = p;
        target  = {t2, t1, t0};
        drained = drn;
        q_commit.push_back(exp_commit);
        @(posedge clk);
        #1;
    endtask

    task automatic trigger(input logic [2:0] v, input logic [2:0] p, input logic [31:0] t2,
                           input logic [31:0] t1, input logic [31:0] t0,
                           input logic [2:0] exp_commit, input logic [31:0] exp_pc);
        redir_t r;
        exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'd1;
        r.pc    = exp_pc;
        r.cnt   = exp_cnt;
        q_redir.push_back(r);
        step(v, p, t2, t1, t0, 1'b1, exp_commit);
        chk("hold_after_trigger", 32'(hold), 32'd1);
    endtask

    // Trigger, then FLUSH and two DRAIN cycles with the store queue already drained.
    task automatic run_recovery(input logic [2:0] v, input logic [2:0] p, input logic [31:0] t2,
                                input logic [31:0] t1, input logic [31:0] t0,
                                input logic [2:0] exp_commit, input logic [31:0] exp_pc);
        trigger(v, p, t2, t1, t0, exp_commit, exp_pc);
        step(3'b111, 3'b000, 0, 0, 0, 1'b1, 3'b000);
        chk("pulse_cleared", 32'({bp, rv}), 32'd0);
        chk("hold_in_drain", 32'(hold), 32'd1);
        step(3'b111, 3'b000, 0, 0, 0, 1'b1, 3'b000);
        step(3'b111, 3'b000, 0, 0, 0, 1'b1, 3'b000);
        chk("hold_released", 32'(hold), 32'd0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        exp_cnt = 4'd0;
        prev_bp = 1'b0;
        rst_n   = 1'b0;
        valid   = '0;
        precise = '0;
        target  = '0;
        drained = 1'b1;
        #1;
        chk("reset_bp", 32'(bp), 32'd0);
        chk("reset_rv", 32'(rv), 32'd0);
        chk("reset_pc", pc, 32'd0);
        chk("reset_hold", 32'(hold), 32'd0);
        chk("reset_count", 32'(cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // No hits: everything commits, nothing recovers.
        for (int i = 0; i < 10; i++) step(3'b111, 3'b000, 0, 0, 0, 1'b1, 3'b111);
        chk("idle_hold", 32'(hold), 32'd0);
        chk("idle_count", 32'(cnt), 32'd0);

        // Single hit in slot 1, low PC bits dropped.
        run_recovery(3'b111, 3'b010, 32'h0, 32'h1003, 32'h0, 3'b110, 32'h1000);
        chk("pc_holds", pc, 32'h1000);
        chk("rv_low_after", 32'(rv), 32'd0);

        // Two hits: oldest (slot 1) wins, younger slot 0 discarded.
        run_recovery(3'b111, 3'b011, 32'h0, 32'h200, 32'h300, 3'b110, 32'h200);
        chk("count_after_multi", 32'(cnt), 32'd2);

        // Drain waits for the store queue; a hit meanwhile is ignored.
        trigger(3'b111, 3'b100, 32'h4007, 32'h0, 32'h0, 3'b100, 32'h4004);
        step(3'b000, 3'b000, 0, 0, 0, 1'b0, 3'b000);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) step(3'b111, 3'b111, 32'h9990, 32'h9994, 32'h9998, 1'b0, 3'b000);
            else step(3'b000, 3'b000, 0, 0, 0, 1'b0, 3'b000);
            chk("hold_while_sq_busy", 32'(hold), 32'd1);
        end
        step(3'b000, 3'b000, 0, 0, 0, 1'b1, 3'b000);
        chk("hold_drop_on_drain", 32'(hold), 32'd0);
        chk("count_no_retrigger", 32'(cnt), 32'd3);
        chk("pc_kept_after_drain", pc, 32'h4004);

        // Precise bit on an invalid slot is not a hit.
        step(3'b010, 3'b101, 32'h5000, 32'h6000, 32'h7000, 1'b1, 3'b010);
        step(3'b000, 3'b000, 0, 0, 0, 1'b1, 3'b000);
        chk("invalid_precise_ignored", 32'(cnt), 32'd3);

        // Asynchronous reset in the middle of DRAIN.
        trigger(3'b001, 3'b001, 32'h0, 32'h0, 32'h8002, 3'b001, 32'h8000);
        step(3'b111, 3'b000, 0, 0, 0, 1'b1, 3'b000);
        step(3'b000, 3'b000, 0, 0, 0, 1'b1, 3'b000);
        valid   = 3'b111;
        precise = 3'b000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_bp", 32'(bp), 32'd0);
        chk("arst_rv", 32'(rv), 32'd0);
        chk("arst_pc", pc, 32'd0);
        chk("arst_hold", 32'(hold), 32'd0);
        chk("arst_count", 32'(cnt), 32'd0);
        chk("arst_commit_idle", 32'(commit), 32'd7);
        exp_cnt = 4'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_recovery(3'b111, 3'b100, 32'h000C, 32'h0, 32'h0, 3'b100, 32'h000C);

        // Counter saturation: 16 more recoveries push past 4'hF.
        for (int i = 1; i <= 16; i++) begin
            run_recovery(3'b111, 3'b010, 32'h0, 32'(i * 256 + 3), 32'h0, 3'b110,
                         32'(i * 256));
        end
        chk("count_saturated", 32'(cnt), 32'hF);

        @(negedge clk);
        #1;
        chk("commit_queue_empty", 32'(q_commit.size()), 32'd0);
        chk("redirect_queue_empty", 32'(q_redir.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
